// File: rtl/apb4_req_master.sv
// rtl/apb4_req_master.sv - single-outstanding APB4 master with valid/ready request and response channels
module apb4_req_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_write_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_strb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [2:0]              pprot,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit              TO_EN    = (TIMEOUT != 0);

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    // Bus control decodes straight from state so an async reset drops psel/penable at once.
    assign req_ready_o = (state == ST_IDLE);
    assign psel        = (state == ST_SETUP) || (state == ST_ACCESS);
    assign penable     = (state == ST_ACCESS);
    assign rsp_valid_o = (state == ST_RESP);
    assign pprot       = 3'b000;
    assign timeout_hit = TO_EN && (wait_cnt == CNT_LAST);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            paddr         <= '0;
            pwrite        <= 1'b0;
            pwdata        <= '0;
            pstrb         <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        paddr    <= req_addr_i & ~ADDR_WIDTH'(3);
                        pwrite   <= req_write_i;
                        pwdata   <= req_wdata_i;
                        pstrb    <= req_write_i ? req_strb_i : '0;
                        wait_cnt <= '0;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // pready wins over a timeout landing in the same cycle.
                    if (pready) begin
                        rsp_rdata_o   <= pwrite ? '0 : prdata;
                        rsp_err_o     <= pslverr;
                        rsp_timeout_o <= 1'b0;
                        state         <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata_o   <= '0;
                        rsp_err_o     <= 1'b1;
                        rsp_timeout_o <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb4_req_master.sv
// tb/tb_apb4_req_master.sv - scoreboard bench for apb4_req_master against a small APB slave model
module tb_apb4_req_master;

    logic        pclk;
    logic        presetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    logic        req_valid0;
    logic        req_ready0;
    logic        rsp_valid0;
    logic [31:0] rsp_rdata0;
    logic        rsp_err0;
    logic        rsp_timeout0;
    logic [31:0] paddr0;
    logic [2:0]  pprot0;
    logic        psel0;
    logic        penable0;
    logic        pwrite0;
    logic [31:0] pwdata0;
    logic [3:0]  pstrb0;
    logic        pready0;

    apb4_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) u_dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
        .paddr(paddr), .pprot(pprot), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb4_req_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(0)) u_dut0 (
        .pclk(pclk), .presetn(presetn),
        .req_valid_i(req_valid0), .req_ready_o(req_ready0), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
        .rsp_valid_o(rsp_valid0), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata0),
        .rsp_err_o(rsp_err0), .rsp_timeout_o(rsp_timeout0),
        .paddr(paddr0), .pprot(pprot0), .psel(psel0), .penable(penable0), .pwrite(pwrite0),
        .pwdata(pwdata0), .pstrb(pstrb0), .prdata(32'h0), .pready(pready0), .pslverr(1'b0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rsp_seen = 0;
    logic [31:0] mem[16];
    int          slv_wait = 0;
    logic        slv_hang = 0;
    logic        slv_err = 0;
    int          slv_cnt = 0;
    logic [31:0] setup_addr, setup_wdata;
    logic [3:0]  setup_strb;
    int          pen_cnt = 0;
    logic        unstable = 0;

    initial pclk = 0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // APB slave model: wait states, hang, and pslverr held high while not ready.
    always @(negedge pclk) begin
        if (psel && penable) begin
            if (!slv_hang && slv_cnt >= slv_wait) begin
                pready  = 1;
                pslverr = slv_err;
                prdata  = pwrite ? 32'hFFFF_FFFF : mem[paddr[5:2]];
                if (pwrite)
                    for (int b = 0; b < 4; b++)
                        if (pstrb[b]) mem[paddr[5:2]][8*b +: 8] = pwdata[8*b +: 8];
            end else begin
                pready  = 0;
                pslverr = 1;
                prdata  = 32'hBAD0_BAD0;
            end
            slv_cnt++;
        end else begin
            pready  = 0;
            pslverr = 0;
            slv_cnt = 0;
        end
    end

    // Bus observer and response scoreboard.
    always @(negedge pclk) begin
        if (presetn) begin
            if (psel && !penable) begin
                setup_addr  = paddr;
                setup_wdata = pwdata;
                setup_strb  = pstrb;
                pen_cnt     = 0;
                unstable    = 0;
            end
            if (psel && penable) begin
                pen_cnt++;
                if (paddr !== setup_addr || pwdata !== setup_wdata || pstrb !== setup_strb)
                    unstable = 1;
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                    check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.to});
                end
                rsp_seen++;
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] e_rdata, input logic e_err,
                          input logic e_to, input int e_lat, input int e_pen, input int hold);
        int   lat;
        int   n;
        int   seen0;
        exp_t e;
        seen0 = rsp_seen;
        @(negedge pclk);
        req_addr  = addr;
        req_write = wr;
        req_wdata = wdata;
        req_strb  = strb;
        req_valid = 1;
        rsp_ready = (hold == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge pclk);
            n++;
        end
        if (n == 50) check("req_ready_timeout", 32'd0, 32'd1);
        e.rdata = e_rdata;
        e.err   = e_err;
        e.to    = e_to;
        exp_q.push_back(e);
        @(posedge pclk);
        #1 req_valid = 0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge pclk);
            lat++;
        end
        if (lat == 100) check("rsp_valid_timeout", 32'd0, 32'd1);
        check("latency", lat, e_lat);
        for (int i = 0; i < hold; i++) begin
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
            check("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
            check("hold_rsp_rdata", rsp_rdata, e_rdata);
            check("hold_rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
            @(negedge pclk);
        end
        if (hold != 0) begin
            @(posedge pclk);
            #1 rsp_ready = 1;
        end
        n = 0;
        while (rsp_seen == seen0 && n < 50) begin
            @(negedge pclk);
            #1 n++;
        end
        if (n == 50) check("rsp_handshake_timeout", 32'd0, 32'd1);
        check("penable_cycles", pen_cnt, e_pen);
        check("bus_stable", {31'b0, unstable}, 32'd0);
        check("paddr_aligned", setup_addr, addr & ~32'h3);
        check("pstrb", {28'b0, setup_strb}, {28'b0, (wr ? strb : 4'h0)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0]  = 32'h101F_1010;
        mem[15] = 32'hDEAD_BEEF;
        presetn = 0; req_valid = 0; req_valid0 = 0; rsp_ready = 1; pready0 = 0;
        req_addr = 0; req_write = 0; req_wdata = 0; req_strb = 0;
        pready = 0; pslverr = 0; prdata = 0;
        #12;
        check("rst_psel", {31'b0, psel}, 32'd0);
        check("rst_penable", {31'b0, penable}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_paddr", paddr, 32'd0);
        check("rst_pstrb", {28'b0, pstrb}, 32'd0);
        check("rst_rsp_err", {30'b0, rsp_err, rsp_timeout}, 32'd0);
        check("rst_pprot", {29'b0, pprot}, 32'd0);
        @(negedge pclk);
        presetn = 1;
        @(negedge pclk);
        check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

        do_req(32'h00, 0, 32'h0,         4'h0, 32'h101F_1010, 0, 0, 3, 1, 0);
        do_req(32'h04, 1, 32'h0000_1234, 4'hF, 32'h0,         0, 0, 3, 1, 0);
        do_req(32'h04, 0, 32'h0,         4'hF, 32'h0000_1234, 0, 0, 3, 1, 0);
        do_req(32'h06, 0, 32'h0,         4'h0, 32'h0000_1234, 0, 0, 3, 1, 0);
        do_req(32'h08, 1, 32'hAABB_CCDD, 4'h5, 32'h0,         0, 0, 3, 1, 0);
        do_req(32'h08, 0, 32'h0,         4'h0, 32'h00BB_00DD, 0, 0, 3, 1, 0);

        slv_wait = 5;
        do_req(32'h04, 1, 32'h5555_0001, 4'h3, 32'h0,         0, 0, 8, 6, 0);
        do_req(32'h04, 0, 32'h0,         4'h0, 32'h0000_0001, 0, 0, 8, 6, 0);
        slv_wait = 0;

        slv_hang = 1;
        do_req(32'h0C, 1, 32'hCAFE_F00D, 4'hF, 32'h0,         1, 1, 18, 16, 0);
        slv_hang = 0;

        slv_err = 1;
        do_req(32'h3C, 0, 32'h0,         4'h0, 32'hDEAD_BEEF, 1, 0, 3, 1, 3);
        slv_err = 0;

        @(negedge pclk);
        req_addr = 32'h10; req_write = 0; req_valid0 = 1;
        @(posedge pclk);
        #1 req_valid0 = 0;
        repeat (40) @(negedge pclk);
        check("to0_psel_held", {31'b0, psel0}, 32'd1);
        check("to0_penable_held", {31'b0, penable0}, 32'd1);
        check("to0_no_rsp", {31'b0, rsp_valid0}, 32'd0);

        slv_hang = 1;
        @(negedge pclk);
        req_addr = 32'h00; req_write = 0; req_valid = 1;
        @(posedge pclk);
        #1 req_valid = 0;
        repeat (3) @(negedge pclk);
        check("pre_rst_penable", {31'b0, penable}, 32'd1);
        @(posedge pclk);
        #3 presetn = 0;
        #1;
        check("async_rst_psel", {31'b0, psel}, 32'd0);
        check("async_rst_penable", {31'b0, penable}, 32'd0);
        check("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("async_rst_psel0", {31'b0, psel0}, 32'd0);
        repeat (2) @(negedge pclk);
        presetn = 1;
        slv_hang = 0;
        repeat (10) @(negedge pclk);
        check("post_rst2_req_ready", {31'b0, req_ready}, 32'd1);
        check("post_rst2_rsp_valid", {31'b0, rsp_valid}, 32'd0);

        do_req(32'h00, 0, 32'h0, 4'h0, 32'h101F_1010, 0, 0, 3, 1, 0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
